trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Machine-mode trap sequencer at the commit stage. Picks the committing instruction's
//  exception or the highest-priority enabled interrupt, updates mepc/mcause/mtval/mstatus/priv,
//  flushes the pipeline, waits for drain, then redirects fetch. Also sequences MRET and owns
//  the trap CSRs (mstatus, mie, mtvec, mepc, mcause, mtval) for the CSR unit.
// PARAMETERS
//  XLEN       64                        datapath width (equal to riscv_pkg::RV_XLEN)
//  BOOT_TVEC  64'h0000_0000_8000_0000   mtvec reset value
// PORTS
//  clk            in   1     clock; single clock domain
//  rst            in   1     synchronous, active-high reset
//  commit_valid_i in   1     instruction at commit (consumed only when commit_ready_o=1)
//  commit_ready_o out  1     1 only in IDLE
//  commit_pc_i    in   XLEN  committing pc
//  commit_ex_i    in   1     synchronous exception on this instruction
//  commit_cause_i in   XLEN  exception cause (ex_cause_t encoding)
//  commit_tval_i  in   XLEN  exception tval
//  commit_ecall_i in   1     ECALL; cause is chosen from priv by this block
//  commit_mret_i  in   1     MRET
//  meip_i/mtip_i/msip_i in 1 level-sensitive external/timer/software interrupt lines
//  flush_o        out  1     kill all in-flight instructions
//  drained_i      in   1     pipeline empty after flush
//  redirect_valid_o out 1    fetch redirect request
//  redirect_ready_i in  1    fetch accepted redirect
//  redirect_pc_o  out  XLEN  redirect target
//  priv_o         out  2     current priv_lvl_t (M or U only)
//  csr_we_i       in   1     CSR write strobe
//  csr_addr_i     in   12    CSR address (read and write)
//  csr_wdata_i    in   XLEN  CSR write data
//  csr_rdata_o    out  XLEN  combinational read data; 0 for unowned addresses
// BEHAVIOUR
//  Reset: state IDLE, priv=M, mstatus.mie=0, mpie=0, mpp=M, mie/mepc/mcause/mtval=0, mtvec=BOOT_TVEC;
//   flush_o=0, redirect_valid_o=0, commit_ready_o=1. Reset mid-sequence aborts to IDLE next edge.
//  States: IDLE -> FLUSH -> REDIRECT -> IDLE.
//  Event in IDLE at cycle T: commit_valid_i & (intr_pend | commit_ex_i | commit_ecall_i | commit_mret_i).
//   intr_pend = |(mip & mie) & (priv==U | mstatus.mie); mip bits 11/7/3 = meip/mtip/msip.
//   Priority: interrupt (MEI > MSI > MTI) > exception > ecall > mret. Instruction is not retired.
//  Trap at edge T+1: mepc=commit_pc_i with bits[1:0] cleared; mcause=cause (interrupts {1,idx});
//   ecall cause=ENV_CALL_UMODE/MMODE by priv; mtval=commit_tval_i for exceptions, else 0;
//   mpie=mie, mie=0, mpp=priv, priv=M.
//   target = {mtvec[XLEN-1:2],2'b0}, plus 4*idx for interrupts when mtvec[1:0]==1.
//  MRET at edge T+1: mie=mpie, mpie=1, priv=mpp, mpp=U; target=mepc.
//  FLUSH: flush_o=1, redirect_valid_o=0. On drained_i=1, go to REDIRECT next cycle;
//   drained_i already 1 on entry still costs one FLUSH cycle.
//  REDIRECT: redirect_valid_o=1 and redirect_pc_o stable until redirect_ready_i; then IDLE.
//   Min latency: event T -> redirect_valid_o high at T+2.
//  CSRs: 0x300 mstatus (mie[3], mpie[7], mpp[12:11]; other bits read 0; mpp write of 2'b01/10 -> U),
//   0x304 mie (bits 11/7/3 only), 0x305 mtvec (mode 2,3 -> 0), 0x341 mepc (bits[1:0]=0),
//   0x342 mcause, 0x343 mtval, 0x344 mip (read-only).
//  csr_we_i is ignored unless state==IDLE. A same-cycle trap or MRET update beats csr_we_i.
//  Interrupt lines change while not IDLE: no effect until the next IDLE commit.
// TESTING
//  Reset, then commit_ex_i cause=2 at pc 0x8000_0104, tval=0xdead -> flush_o T+1, drained_i T+2,
//   redirect 0x8000_0000 at T+3; mcause=2, mepc=0x8000_0104, mtval=0xdead, priv=M.
//  mtvec=0x8000_0001, mie=0x80, mstatus.mie=1, mtip_i=1, commit pc 0x100 ->
//   mcause=0x8000_0000_0000_0007, redirect 0x8000_001C, mie=0, mpie=1.
//  meip_i+msip_i+mtip_i all high with commit_ex_i -> mcause=...000B (MEI wins), mtval=0.
//  mpp=U, mepc=0x2000, commit_mret_i -> redirect 0x2000, priv=U, mie=mpie, mpp=U;
//   then commit_ecall_i -> mcause=8.
//  redirect_ready_i held 0 for 5 cycles -> redirect_valid_o/pc stable, commit_ready_o=0 throughout.
//  rst pulsed during FLUSH -> next cycle flush_o=0, state IDLE, all CSRs at reset values.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap and MRET sequencer at the commit stage. Owns mstatus, mie,
// mtvec, mepc, mcause and mtval, and runs the flush -> drain -> redirect handshake.
module trap_ctrl #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] BOOT_TVEC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid_i,
  output logic            commit_ready_o,
  input  logic [XLEN-1:0] commit_pc_i,
  input  logic            commit_ex_i,
  input  logic [XLEN-1:0] commit_cause_i,
  input  logic [XLEN-1:0] commit_tval_i,
  input  logic            commit_ecall_i,
  input  logic            commit_mret_i,
  input  logic            meip_i,
  input  logic            mtip_i,
  input  logic            msip_i,
  output logic            flush_o,
  input  logic            drained_i,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [1:0]      priv_o,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o
);

  localparam logic [1:0]      PRIV_M        = 2'b11;
  localparam logic [1:0]      PRIV_U        = 2'b00;
  localparam logic [11:0]     CSR_MSTATUS   = 12'h300;
  localparam logic [11:0]     CSR_MIE       = 12'h304;
  localparam logic [11:0]     CSR_MTVEC     = 12'h305;
  localparam logic [11:0]     CSR_MEPC      = 12'h341;
  localparam logic [11:0]     CSR_MCAUSE    = 12'h342;
  localparam logic [11:0]     CSR_MTVAL     = 12'h343;
  localparam logic [11:0]     CSR_MIP       = 12'h344;
  localparam logic [XLEN-1:0] MIE_MASK      = XLEN'(12'h888);
  localparam logic [XLEN-1:0] LOW2_MASK     = ~XLEN'(2'b11);
  localparam logic [XLEN-1:0] CAUSE_ECALL_U = XLEN'(4'd8);
  localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(4'd11);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            flush_q, flush_d;
  logic            rvalid_q, rvalid_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [1:0]      priv_q, priv_d;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mpie_q, mpie_d;
  logic [1:0]      mpp_q, mpp_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  logic [XLEN-1:0] mip_s;
  logic [XLEN-1:0] pend_s;
  logic [XLEN-1:0] mstatus_s;
  logic            intr_en_s;
  logic [3:0]      intr_idx_s;
  logic            idle_s;
  logic            evt_s;
  logic            trap_s;
  logic            mret_s;
  logic            csr_wr_s;
  logic [XLEN-1:0] trap_cause_s;
  logic [XLEN-1:0] trap_tval_s;
  logic [XLEN-1:0] trap_tgt_s;

  // Event decode: interrupt selection, trap cause/tval and trap target.
  always_comb begin
    mip_s        = '0;
    mip_s[11]    = meip_i;
    mip_s[7]     = mtip_i;
    mip_s[3]     = msip_i;
    mstatus_s    = '0;
    mstatus_s[3] = mstatus_mie_q;
    mstatus_s[7] = mpie_q;
    mstatus_s[12:11] = mpp_q;
    pend_s       = mip_s & mie_q;
    intr_en_s    = (|pend_s) && ((priv_q == PRIV_U) || mstatus_mie_q);

    // Fixed priority MEI > MSI > MTI.
    if (pend_s[11]) begin
      intr_idx_s = 4'd11;
    end else if (pend_s[3]) begin
      intr_idx_s = 4'd3;
    end else if (pend_s[7]) begin
      intr_idx_s = 4'd7;
    end else begin
      intr_idx_s = 4'd0;
    end

    idle_s   = (state_q == S_IDLE);
    evt_s    = idle_s && commit_valid_i &&
               (intr_en_s || commit_ex_i || commit_ecall_i || commit_mret_i);
    trap_s   = evt_s && (intr_en_s || commit_ex_i || commit_ecall_i);
    mret_s   = evt_s && !trap_s;
    csr_wr_s = csr_we_i && idle_s && !evt_s;

    if (intr_en_s) begin
      trap_cause_s = {1'b1, {(XLEN-5){1'b0}}, intr_idx_s};
      trap_tval_s  = '0;
    end else if (commit_ex_i) begin
      trap_cause_s = commit_cause_i;
      trap_tval_s  = commit_tval_i;
    end else if (priv_q == PRIV_U) begin
      trap_cause_s = CAUSE_ECALL_U;
      trap_tval_s  = '0;
    end else begin
      trap_cause_s = CAUSE_ECALL_M;
      trap_tval_s  = '0;
    end

    if (intr_en_s && (mtvec_q[1:0] == 2'b01)) begin
      trap_tgt_s = (mtvec_q & LOW2_MASK) + XLEN'({intr_idx_s, 2'b00});
    end else begin
      trap_tgt_s = mtvec_q & LOW2_MASK;
    end
  end

  // Next-state logic for the sequencer and every trap CSR.
  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    flush_d       = flush_q;
    rvalid_d      = rvalid_q;
    rpc_d         = rpc_q;
    priv_d        = priv_q;
    mstatus_mie_d = mstatus_mie_q;
    mpie_d        = mpie_q;
    mpp_d         = mpp_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;

    case (state_q)
      S_IDLE: begin
        if (evt_s) begin
          state_d  = S_FLUSH;
          ready_d  = 1'b0;
          flush_d  = 1'b1;
          rvalid_d = 1'b0;
          rpc_d    = trap_s ? trap_tgt_s : mepc_q;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (drained_i) begin
          state_d  = S_REDIRECT;
          flush_d  = 1'b0;
          rvalid_d = 1'b1;
        end else begin
          state_d  = S_FLUSH;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
          ready_d  = 1'b1;
        end else begin
          state_d  = S_REDIRECT;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ready_d  = 1'b1;
        flush_d  = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase

    // A trap or MRET in the same cycle as a CSR write takes precedence.
    if (trap_s) begin
      mepc_d        = commit_pc_i & LOW2_MASK;
      mcause_d      = trap_cause_s;
      mtval_d       = trap_tval_s;
      mpie_d        = mstatus_mie_q;
      mstatus_mie_d = 1'b0;
      mpp_d         = priv_q;
      priv_d        = PRIV_M;
    end else if (mret_s) begin
      mstatus_mie_d = mpie_q;
      mpie_d        = 1'b1;
      priv_d        = mpp_q;
      mpp_d         = PRIV_U;
    end else if (csr_wr_s) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_d = csr_wdata_i[3];
          mpie_d        = csr_wdata_i[7];
          mpp_d         = (csr_wdata_i[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
        end
        CSR_MIE:    mie_d    = csr_wdata_i & MIE_MASK;
        CSR_MTVEC:  mtvec_d  = csr_wdata_i[1] ? (csr_wdata_i & LOW2_MASK) : csr_wdata_i;
        CSR_MEPC:   mepc_d   = csr_wdata_i & LOW2_MASK;
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        CSR_MTVAL:  mtval_d  = csr_wdata_i;
        default:    mie_d    = mie_q;
      endcase
    end else begin
      priv_d = priv_q;
    end
  end

  // State and CSR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      flush_q       <= 1'b0;
      rvalid_q      <= 1'b0;
      rpc_q         <= '0;
      priv_q        <= PRIV_M;
      mstatus_mie_q <= 1'b0;
      mpie_q        <= 1'b0;
      mpp_q         <= PRIV_M;
      mie_q         <= '0;
      mtvec_q       <= BOOT_TVEC;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      flush_q       <= flush_d;
      rvalid_q      <= rvalid_d;
      rpc_q         <= rpc_d;
      priv_q        <= priv_d;
      mstatus_mie_q <= mstatus_mie_d;
      mpie_q        <= mpie_d;
      mpp_q         <= mpp_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
    end
  end

  // CSR read mux; unowned addresses read zero.
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS: csr_rdata_o = mstatus_s;
      CSR_MIE:     csr_rdata_o = mie_q;
      CSR_MTVEC:   csr_rdata_o = mtvec_q;
      CSR_MEPC:    csr_rdata_o = mepc_q;
      CSR_MCAUSE:  csr_rdata_o = mcause_q;
      CSR_MTVAL:   csr_rdata_o = mtval_q;
      CSR_MIP:     csr_rdata_o = mip_s;
      default:     csr_rdata_o = '0;
    endcase
  end

  assign commit_ready_o   = ready_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = rvalid_q;
  assign redirect_pc_o    = rpc_q;
  assign priv_o           = priv_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios then randomized commits/CSR writes,
// checked against a behavioural model of the machine-mode trap rules.
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        commit_valid_i;
  logic        commit_ready_o;
  logic [63:0] commit_pc_i;
  logic        commit_ex_i;
  logic [63:0] commit_cause_i;
  logic [63:0] commit_tval_i;
  logic        commit_ecall_i;
  logic        commit_mret_i;
  logic        meip_i, mtip_i, msip_i;
  logic        flush_o;
  logic        drained_i;
  logic        redirect_valid_o;
  logic        redirect_ready_i;
  logic [63:0] redirect_pc_o;
  logic [1:0]  priv_o;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic [63:0] csr_rdata_o;

  trap_ctrl #(.XLEN(64), .BOOT_TVEC(64'h0000_0000_8000_0000)) dut (
    .clk(clk), .rst(rst),
    .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
    .commit_pc_i(commit_pc_i), .commit_ex_i(commit_ex_i),
    .commit_cause_i(commit_cause_i), .commit_tval_i(commit_tval_i),
    .commit_ecall_i(commit_ecall_i), .commit_mret_i(commit_mret_i),
    .meip_i(meip_i), .mtip_i(mtip_i), .msip_i(msip_i),
    .flush_o(flush_o), .drained_i(drained_i),
    .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
    .redirect_pc_o(redirect_pc_o), .priv_o(priv_o),
    .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference architectural state
  logic [1:0]  m_priv, m_mpp;
  logic        m_smie, m_mpie;
  logic [63:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_priv = 2'b11; m_smie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b11;
    m_mie = 64'd0; m_mtvec = 64'h8000_0000; m_mepc = 64'd0;
    m_mcause = 64'd0; m_mtval = 64'd0;
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (64'(m_smie) << 3) | (64'(m_mpie) << 7) | (64'(m_mpp) << 11);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (64'(meip_i) << 11) | (64'(mtip_i) << 7) | (64'(msip_i) << 3);
      default: return 64'd0;
    endcase
  endfunction

  task automatic m_csr_write(input logic [11:0] a, input logic [63:0] wd);
    case (a)
      12'h300: begin
        m_smie = wd[3]; m_mpie = wd[7];
        m_mpp  = (wd[12:11] == 2'b11) ? 2'b11 : 2'b00;
      end
      12'h304: m_mie = wd & 64'h888;
      12'h305: m_mtvec = (wd[1:0] >= 2'd2) ? {wd[63:2], 2'b00} : wd;
      12'h341: m_mepc = {wd[63:2], 2'b00};
      12'h342: m_mcause = wd;
      12'h343: m_mtval = wd;
      default: ;
    endcase
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] wd);
    csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = wd;
    @(posedge clk); @(negedge clk);
    csr_we_i = 1'b0;
    m_csr_write(a, wd);
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr_addr_i = a; #1;
    chk(tag, csr_rdata_o, exp);
    @(negedge clk);
  endtask

  task automatic check_csrs(input string tag);
    logic [11:0] addrs [8];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7c0};
    for (int i = 0; i < 8; i++) begin
      csr_addr_i = addrs[i]; #1;
      chk($sformatf("%s_csr%03h", tag, addrs[i]), csr_rdata_o, m_read(addrs[i]));
      @(negedge clk);
    end
    chk($sformatf("%s_priv", tag), 64'(priv_o), 64'(m_priv));
  endtask

  // One commit: model decides the outcome, then the full handshake is driven and checked.
  task automatic run_event(input logic [63:0] pc, input logic ex, input logic [63:0] cause,
                           input logic [63:0] tval, input logic ecall, input logic mret,
                           input int d, input int h, input logic clash, input logic noisy,
                           output logic [63:0] obs_pc);
    logic [63:0] mip, tgt;
    int idx, kind;
    int order [3];
    order[0] = 11; order[1] = 3; order[2] = 7;
    mip = (64'(meip_i) << 11) | (64'(mtip_i) << 7) | (64'(msip_i) << 3);
    idx = -1;
    if (((mip & m_mie) != 64'd0) && ((m_priv == 2'b00) || m_smie))
      for (int i = 0; i < 3; i++)
        if (idx < 0 && mip[order[i]] && m_mie[order[i]]) idx = order[i];
    if (idx >= 0) kind = 1;
    else if (ex) kind = 2;
    else if (ecall) kind = 3;
    else if (mret) kind = 4;
    else kind = 0;
    obs_pc = 64'd0;

    chk("ready_before", 64'(commit_ready_o), 64'd1);
    commit_valid_i = 1'b1; commit_pc_i = pc; commit_ex_i = ex; commit_cause_i = cause;
    commit_tval_i = tval; commit_ecall_i = ecall; commit_mret_i = mret;
    if (clash && kind != 0) begin
      csr_we_i = 1'b1; csr_addr_i = 12'h300; csr_wdata_i = {$urandom, $urandom};
    end
    @(posedge clk); @(negedge clk);
    commit_valid_i = 1'b0; commit_ex_i = 1'b0; commit_ecall_i = 1'b0;
    commit_mret_i = 1'b0; csr_we_i = 1'b0;

    if (kind == 0) begin
      chk("retire_flush", 64'(flush_o), 64'd0);
      chk("retire_ready", 64'(commit_ready_o), 64'd1);
      return;
    end

    if (kind == 4) begin
      tgt = m_mepc;
      m_smie = m_mpie; m_mpie = 1'b1; m_priv = m_mpp; m_mpp = 2'b00;
    end else begin
      tgt = {m_mtvec[63:2], 2'b00};
      if (kind == 1 && m_mtvec[1:0] == 2'b01) tgt = tgt + 64'(4 * idx);
      m_mepc   = {pc[63:2], 2'b00};
      m_mcause = (kind == 1) ? ((64'd1 << 63) | 64'(idx)) :
                 (kind == 2) ? cause : ((m_priv == 2'b00) ? 64'd8 : 64'd11);
      m_mtval  = (kind == 2) ? tval : 64'd0;
      m_mpie = m_smie; m_smie = 1'b0; m_mpp = m_priv; m_priv = 2'b11;
    end

    for (int k = 0; k < d; k++) begin
      chk("flush_hold", 64'(flush_o), 64'd1);
      chk("flush_no_redir", 64'(redirect_valid_o), 64'd0);
      chk("flush_ready", 64'(commit_ready_o), 64'd0);
      if (noisy) begin
        csr_we_i = 1'b1; csr_addr_i = 12'h305; csr_wdata_i = {$urandom, $urandom};
        meip_i = 1'($urandom_range(0, 1)); mtip_i = 1'($urandom_range(0, 1));
        msip_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); @(negedge clk);
    end
    chk("flush_last", 64'(flush_o), 64'd1);
    chk("flush_last_ready", 64'(commit_ready_o), 64'd0);
    drained_i = 1'b1;
    @(posedge clk); @(negedge clk);
    drained_i = 1'b0;
    obs_pc = redirect_pc_o;
    for (int k = 0; k <= h; k++) begin
      chk("redir_valid", 64'(redirect_valid_o), 64'd1);
      chk("redir_pc", redirect_pc_o, tgt);
      chk("redir_flush", 64'(flush_o), 64'd0);
      chk("redir_ready", 64'(commit_ready_o), 64'd0);
      if (k < h) begin
        @(posedge clk); @(negedge clk);
      end
    end
    csr_we_i = 1'b0;
    redirect_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    redirect_ready_i = 1'b0;
    chk("back_ready", 64'(commit_ready_o), 64'd1);
    chk("back_valid", 64'(redirect_valid_o), 64'd0);
    chk("back_flush", 64'(flush_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pc;
    logic [11:0] waddrs [8];
    clk = 1'b0; rst = 1'b1;
    commit_valid_i = 1'b0; commit_pc_i = 64'd0; commit_ex_i = 1'b0; commit_cause_i = 64'd0;
    commit_tval_i = 64'd0; commit_ecall_i = 1'b0; commit_mret_i = 1'b0;
    meip_i = 1'b0; mtip_i = 1'b0; msip_i = 1'b0; drained_i = 1'b0; redirect_ready_i = 1'b0;
    csr_we_i = 1'b0; csr_addr_i = 12'h000; csr_wdata_i = 64'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();

    // Reset state
    chk("rst_ready", 64'(commit_ready_o), 64'd1);
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_redir", 64'(redirect_valid_o), 64'd0);
    chk("rst_priv", 64'(priv_o), 64'd3);
    rd("rst_mstatus", 12'h300, 64'h1800);
    rd("rst_mtvec", 12'h305, 64'h8000_0000);
    check_csrs("rst");

    // Synchronous exception, drained one cycle after flush
    run_event(64'h8000_0104, 1'b1, 64'd2, 64'hdead, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, pc);
    chk("ex_target", pc, 64'h8000_0000);
    rd("ex_mcause", 12'h342, 64'd2);
    rd("ex_mepc", 12'h341, 64'h8000_0104);
    rd("ex_mtval", 12'h343, 64'hdead);
    chk("ex_priv", 64'(priv_o), 64'd3);
    check_csrs("ex");

    // Vectored timer interrupt
    csr_write(12'h305, 64'h8000_0001);
    csr_write(12'h304, 64'h80);
    csr_write(12'h300, 64'h1808);
    mtip_i = 1'b1;
    run_event(64'h100, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, pc);
    chk("mti_target", pc, 64'h8000_001c);
    rd("mti_mcause", 12'h342, 64'h8000_0000_0000_0007);
    rd("mti_mstatus", 12'h300, 64'h1880);
    mtip_i = 1'b0;
    check_csrs("mti");

    // All lines plus exception: external interrupt wins, csr write in same cycle loses
    csr_write(12'h304, 64'h888);
    csr_write(12'h300, 64'h1808);
    meip_i = 1'b1; mtip_i = 1'b1; msip_i = 1'b1;
    run_event(64'h200, 1'b1, 64'd5, 64'h1234, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, pc);
    chk("mei_target", pc, 64'h8000_002c);
    rd("mei_mcause", 12'h342, 64'h8000_0000_0000_000b);
    rd("mei_mtval", 12'h343, 64'd0);
    meip_i = 1'b0; mtip_i = 1'b0; msip_i = 1'b0;
    check_csrs("mei");

    // MRET to user mode, then ECALL from user with a long redirect stall
    csr_write(12'h341, 64'h2000);
    csr_write(12'h300, 64'h0080);
    run_event(64'h400, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, pc);
    chk("mret_target", pc, 64'h2000);
    chk("mret_priv", 64'(priv_o), 64'd0);
    rd("mret_mstatus", 12'h300, 64'h0088);
    run_event(64'h3000, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1, 5, 1'b0, 1'b0, pc);
    rd("ecall_mcause", 12'h342, 64'd8);
    rd("ecall_mstatus", 12'h300, 64'h0080);
    chk("ecall_priv", 64'(priv_o), 64'd3);
    check_csrs("ecall");

    // CSR legalisation
    csr_write(12'h305, 64'h8000_0102);
    rd("mtvec_mode2", 12'h305, 64'h8000_0100);
    csr_write(12'h300, 64'h0888);
    rd("mstatus_mpp01", 12'h300, 64'h0088);
    csr_write(12'h344, 64'hffff_ffff_ffff_ffff);
    rd("mip_ro", 12'h344, 64'd0);
    csr_write(12'h7c0, 64'h1234);
    rd("unowned", 12'h7c0, 64'd0);
    check_csrs("legal");

    // Reset in the middle of FLUSH
    commit_valid_i = 1'b1; commit_ex_i = 1'b1; commit_pc_i = 64'h500; commit_cause_i = 64'd4;
    commit_tval_i = 64'h77;
    @(posedge clk); @(negedge clk);
    commit_valid_i = 1'b0; commit_ex_i = 1'b0;
    chk("mid_flush", 64'(flush_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_reset();
    chk("mid_rst_flush", 64'(flush_o), 64'd0);
    chk("mid_rst_ready", 64'(commit_ready_o), 64'd1);
    chk("mid_rst_redir", 64'(redirect_valid_o), 64'd0);
    check_csrs("mid_rst");

    // Randomized commits and CSR writes
    waddrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h301};
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        csr_write(waddrs[$urandom_range(0, 7)], {$urandom, $urandom});
      end else begin
        meip_i = ($urandom_range(0, 2) == 0); mtip_i = ($urandom_range(0, 2) == 0);
        msip_i = ($urandom_range(0, 2) == 0);
        run_event({$urandom, $urandom}, ($urandom_range(0, 2) == 0), 64'($urandom_range(0, 15)),
                  {$urandom, $urandom}, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc);
      end
      check_csrs($sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
